// File: rtl/dq_enq_sched_pkg.sv
// Shared types and sizing for the dispatch-side enqueue scheduler.
// Width/ImmDepth/BrDepth fix the slot count and index widths for every file
// that imports this package. idx_width() sizes a buffer index and never
// returns less than one bit.
package dq_enq_sched_pkg;

  localparam int unsigned Width    = 4;
  localparam int unsigned ImmDepth = 30;
  localparam int unsigned BrDepth  = 16;
  localparam int unsigned XLen     = 32;

  function automatic int unsigned idx_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned ImmW = idx_width(ImmDepth);
  localparam int unsigned BrW  = idx_width(BrDepth);

  typedef logic [XLen-1:0] imm_t;
  typedef logic [ImmW-1:0] imm_idx_t;
  typedef logic [BrW-1:0]  br_idx_t;

  typedef struct packed {
    logic        taken;
    logic [1:0]  kind;
    logic [31:0] target;
  } branch_info_t;

  // One dispatch group as it sits in the hold stage.
  typedef struct packed {
    logic [Width-1:0]         slot;
    logic [Width-1:0]         need_imm;
    logic [Width-1:0]         need_br;
    imm_t [Width-1:0]         imm_data;
    branch_info_t [Width-1:0] br_data;
  } dsp_group_t;

endpackage

// File: rtl/dq_enq_sched_if.sv
// Dispatch-group handshake between the rename/dispatch stage (master) and
// the enqueue scheduler (slave).
//   dsp_vld  : group offered          dsp_rdy  : group accepted this cycle
//   slot_vld : valid slots            need_imm/need_br : per-slot buffer needs
//   imm_data/br_data : per-slot payloads
interface dq_enq_sched_if;
  import dq_enq_sched_pkg::*;

  logic                     dsp_vld;
  logic                     dsp_rdy;
  logic [Width-1:0]         slot_vld;
  logic [Width-1:0]         need_imm;
  logic [Width-1:0]         need_br;
  imm_t [Width-1:0]         imm_data;
  branch_info_t [Width-1:0] br_data;

  modport master (
    output dsp_vld, slot_vld, need_imm, need_br, imm_data, br_data,
    input  dsp_rdy
  );

  modport slave (
    input  dsp_vld, slot_vld, need_imm, need_br, imm_data, br_data,
    output dsp_rdy
  );

endinterface

// File: rtl/dq_enq_hold.sv
// Hold stage H of the enqueue scheduler: latches one dispatch group and
// keeps it until it fires into the buffers or is squashed.
//   clk, rst : clock, synchronous active-high reset
//   squash_i : drop the held group
//   load_i   : capture grp_i (may coincide with fire_i of the old group)
//   fire_i   : held group enqueued this cycle
//   h_vld_o, h_grp_o : held group state
module dq_enq_hold
  import dq_enq_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       squash_i,
  input  logic       load_i,
  input  logic       fire_i,
  input  dsp_group_t grp_i,
  output logic       h_vld_o,
  output dsp_group_t h_grp_o
);

  logic       h_vld_d, h_vld_q;
  dsp_group_t h_grp_d, h_grp_q;

  always_comb begin
    h_vld_d = h_vld_q;
    h_grp_d = h_grp_q;
    if (squash_i) begin
      h_vld_d = 1'b0;
    end else if (load_i) begin
      // A load in a firing cycle replaces the departing group.
      h_vld_d = 1'b1;
      h_grp_d = grp_i;
    end else if (fire_i) begin
      h_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_vld_q <= 1'b0;
      h_grp_q <= '0;
    end else begin
      h_vld_q <= h_vld_d;
      h_grp_q <= h_grp_d;
    end
  end

  assign h_vld_o = h_vld_q;
  assign h_grp_o = h_grp_q;

endmodule

// File: rtl/dq_enq_sched.sv
// Shares one dispatch group between the immediate and branch dataQue
// buffers. Both buffers are enqueued in the same cycle or not at all; the
// per-slot allocation indices are returned through a registered valid/ready
// output stage.
//   clk, rst        : clock, synchronous active-high reset
//   dsp             : dispatch group handshake (slave side)
//   i_squash        : flush held/output groups, block enqueue this cycle
//   o_imm_enq_*     : immediate buffer enqueue; i_imm_can_enq/i_imm_alloc_id back
//   o_br_enq_*      : branch buffer enqueue;    i_br_can_enq/i_br_alloc_id back
//   o_out_*         : allocated group to issue, i_out_rdy consumes
//   o_stall_cnt     : saturating count of capacity-blocked cycles
module dq_enq_sched
  import dq_enq_sched_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_squash,
  dq_enq_sched_if.slave            dsp,
  output logic                     o_imm_enq_vld,
  output logic [Width-1:0]         o_imm_enq_req,
  output imm_t [Width-1:0]         o_imm_enq_data,
  input  logic                     i_imm_can_enq,
  input  imm_idx_t [Width-1:0]     i_imm_alloc_id,
  output logic                     o_br_enq_vld,
  output logic [Width-1:0]         o_br_enq_req,
  output branch_info_t [Width-1:0] o_br_enq_data,
  input  logic                     i_br_can_enq,
  input  br_idx_t [Width-1:0]      i_br_alloc_id,
  output logic                     o_out_vld,
  input  logic                     i_out_rdy,
  output logic [Width-1:0]         o_out_slot_vld,
  output imm_idx_t [Width-1:0]     o_out_imm_idx,
  output br_idx_t [Width-1:0]      o_out_br_idx,
  output logic [31:0]              o_stall_cnt
);

  logic       h_vld;
  dsp_group_t h_grp;
  dsp_group_t in_grp;
  logic       imm_ok, br_ok, out_free, fire, load, stall;

  always_comb begin
    in_grp          = '0;
    in_grp.slot     = dsp.slot_vld;
    in_grp.need_imm = dsp.need_imm;
    in_grp.need_br  = dsp.need_br;
    in_grp.imm_data = dsp.imm_data;
    in_grp.br_data  = dsp.br_data;
  end

  // Requests are shown whenever a group is held so the buffers can compute
  // can_enq; nothing commits without enq_vld.
  assign o_imm_enq_req  = h_vld ? (h_grp.slot & h_grp.need_imm) : '0;
  assign o_br_enq_req   = h_vld ? (h_grp.slot & h_grp.need_br) : '0;
  assign o_imm_enq_data = h_grp.imm_data;
  assign o_br_enq_data  = h_grp.br_data;

  assign imm_ok   = (o_imm_enq_req == '0) | i_imm_can_enq;
  assign br_ok    = (o_br_enq_req == '0) | i_br_can_enq;
  assign out_free = ~o_out_vld | i_out_rdy;
  assign fire     = h_vld & imm_ok & br_ok & out_free & ~i_squash;
  assign stall    = h_vld & out_free & ~(imm_ok & br_ok) & ~i_squash;

  assign o_imm_enq_vld = fire;
  assign o_br_enq_vld  = fire;

  assign dsp.dsp_rdy = (~h_vld | fire) & ~i_squash;
  // Empty groups are acknowledged but never held.
  assign load        = dsp.dsp_vld & dsp.dsp_rdy & (dsp.slot_vld != '0);

  dq_enq_hold u_hold (
    .clk      (clk),
    .rst      (rst),
    .squash_i (i_squash),
    .load_i   (load),
    .fire_i   (fire),
    .grp_i    (in_grp),
    .h_vld_o  (h_vld),
    .h_grp_o  (h_grp)
  );

  // Output stage O.
  logic                 out_vld_d, out_vld_q;
  logic [Width-1:0]     out_slot_d, out_slot_q;
  imm_idx_t [Width-1:0] out_imm_d, out_imm_q;
  br_idx_t [Width-1:0]  out_br_d, out_br_q;
  logic [31:0]          stall_cnt_d, stall_cnt_q;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_slot_d = out_slot_q;
    out_imm_d  = out_imm_q;
    out_br_d   = out_br_q;
    if (i_squash) begin
      out_vld_d = 1'b0;
    end else if (fire) begin
      out_vld_d  = 1'b1;
      out_slot_d = h_grp.slot;
      // Only slots that actually requested an entry carry a real index.
      for (int i = 0; i < Width; i++) begin
        out_imm_d[i] = o_imm_enq_req[i] ? i_imm_alloc_id[i] : '0;
        out_br_d[i]  = o_br_enq_req[i] ? i_br_alloc_id[i] : '0;
      end
    end else if (out_vld_q && i_out_rdy) begin
      out_vld_d = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q   <= 1'b0;
      out_slot_q  <= '0;
      out_imm_q   <= '0;
      out_br_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_vld_q   <= out_vld_d;
      out_slot_q  <= out_slot_d;
      out_imm_q   <= out_imm_d;
      out_br_q    <= out_br_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_out_vld      = out_vld_q;
  assign o_out_slot_vld = out_slot_q;
  assign o_out_imm_idx  = out_imm_q;
  assign o_out_br_idx   = out_br_q;
  assign o_stall_cnt    = stall_cnt_q;

  a_enq_pair: assert property (@(posedge clk) disable iff (rst)
    o_imm_enq_vld == o_br_enq_vld);
  a_enq_cap: assert property (@(posedge clk) disable iff (rst)
    fire |-> (((o_imm_enq_req == '0) || i_imm_can_enq) &&
              ((o_br_enq_req == '0) || i_br_can_enq)));

endmodule

// File: tb/tb_dq_enq_sched.sv
module tb_dq_enq_sched;
  import dq_enq_sched_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic i_squash;
  logic o_imm_enq_vld, o_br_enq_vld;
  logic [Width-1:0] o_imm_enq_req, o_br_enq_req;
  imm_t [Width-1:0] o_imm_enq_data;
  branch_info_t [Width-1:0] o_br_enq_data;
  logic i_imm_can_enq, i_br_can_enq;
  imm_idx_t [Width-1:0] i_imm_alloc_id;
  br_idx_t [Width-1:0] i_br_alloc_id;
  logic o_out_vld, i_out_rdy;
  logic [Width-1:0] o_out_slot_vld;
  imm_idx_t [Width-1:0] o_out_imm_idx;
  br_idx_t [Width-1:0] o_out_br_idx;
  logic [31:0] o_stall_cnt;

  int checks = 0;
  int failures = 0;

  dq_enq_sched_if dsp_if ();

  dq_enq_sched dut (
    .clk            (clk),
    .rst            (rst),
    .i_squash       (i_squash),
    .dsp            (dsp_if),
    .o_imm_enq_vld  (o_imm_enq_vld),
    .o_imm_enq_req  (o_imm_enq_req),
    .o_imm_enq_data (o_imm_enq_data),
    .i_imm_can_enq  (i_imm_can_enq),
    .i_imm_alloc_id (i_imm_alloc_id),
    .o_br_enq_vld   (o_br_enq_vld),
    .o_br_enq_req   (o_br_enq_req),
    .o_br_enq_data  (o_br_enq_data),
    .i_br_can_enq   (i_br_can_enq),
    .i_br_alloc_id  (i_br_alloc_id),
    .o_out_vld      (o_out_vld),
    .i_out_rdy      (i_out_rdy),
    .o_out_slot_vld (o_out_slot_vld),
    .o_out_imm_idx  (o_out_imm_idx),
    .o_out_br_idx   (o_out_br_idx),
    .o_stall_cnt    (o_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_grp(input logic [3:0] s, input logic [3:0] ni, input logic [3:0] nb);
    dsp_if.slot_vld = s;
    dsp_if.need_imm = ni;
    dsp_if.need_br  = nb;
    for (int i = 0; i < Width; i++) begin
      dsp_if.imm_data[i] = 32'h100 + 32'(i);
      dsp_if.br_data[i]  = '{taken: 1'b1, kind: 2'(i), target: 32'h2000 + 32'(i)};
    end
  endtask

  // Expected masked index vectors: ids are 4..7 (imm) and 9..12 (br).
  function automatic logic [63:0] exp_imm(input logic [3:0] req);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (req[i]) r[i*ImmW +: ImmW] = ImmW'(4 + i);
    return r;
  endfunction

  function automatic logic [63:0] exp_br(input logic [3:0] req);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (req[i]) r[i*BrW +: BrW] = BrW'(9 + i);
    return r;
  endfunction

  logic [3:0] tbl_ni [4];
  logic [3:0] tbl_nb [4];

  initial begin
    tbl_ni = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    tbl_nb = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    for (int i = 0; i < Width; i++) begin
      i_imm_alloc_id[i] = ImmW'(4 + i);
      i_br_alloc_id[i]  = BrW'(9 + i);
    end
    rst = 1'b1;
    i_squash = 1'b0;
    i_imm_can_enq = 1'b1;
    i_br_can_enq = 1'b1;
    i_out_rdy = 1'b1;
    dsp_if.dsp_vld = 1'b0;
    set_grp(4'b0000, 4'b0000, 4'b0000);
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_dsp_rdy", 64'(dsp_if.dsp_rdy), 64'd1);
    chk("rst_out_vld", 64'(o_out_vld), 64'd0);
    chk("rst_stall", 64'(o_stall_cnt), 64'd0);
    chk("rst_enq_vld", 64'({o_imm_enq_vld, o_br_enq_vld}), 64'd0);
    chk("rst_out_idx", 64'(o_out_imm_idx), 64'd0);

    // Basic fire
    set_grp(4'b1111, 4'b0101, 4'b0010);
    dsp_if.dsp_vld = 1'b1;
    settle();
    chk("t1_accept", 64'(dsp_if.dsp_rdy), 64'd1);
    chk("t1_no_enq_yet", 64'(o_imm_enq_vld), 64'd0);
    tick();
    dsp_if.dsp_vld = 1'b0;
    settle();
    chk("t1_imm_req", 64'(o_imm_enq_req), 64'b0101);
    chk("t1_br_req", 64'(o_br_enq_req), 64'b0010);
    chk("t1_enq_vld", 64'({o_imm_enq_vld, o_br_enq_vld}), 64'b11);
    chk("t1_imm_data2", 64'(o_imm_enq_data[2]), 64'h102);
    tick();
    chk("t1_out_vld", 64'(o_out_vld), 64'd1);
    chk("t1_out_slot", 64'(o_out_slot_vld), 64'b1111);
    chk("t1_out_imm", 64'(o_out_imm_idx), exp_imm(4'b0101));
    chk("t1_out_br", 64'(o_out_br_idx), exp_br(4'b0010));
    chk("t1_enq_idle", 64'(o_imm_enq_vld), 64'd0);

    // Branch buffer full for three cycles
    dsp_if.dsp_vld = 1'b1;
    tick();
    dsp_if.dsp_vld = 1'b0;
    i_br_can_enq = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("t2_stall_enq", 64'({o_imm_enq_vld, o_br_enq_vld}), 64'd0);
      chk("t2_stall_rdy", 64'(dsp_if.dsp_rdy), 64'd0);
      tick();
    end
    i_br_can_enq = 1'b1;
    settle();
    chk("t2_stall_cnt", 64'(o_stall_cnt), 64'd3);
    chk("t2_fire", 64'({o_imm_enq_vld, o_br_enq_vld}), 64'b11);
    tick();
    chk("t2_out_br", 64'(o_out_br_idx), exp_br(4'b0010));

    // No buffer needs, both buffers full
    set_grp(4'b0011, 4'b0000, 4'b0000);
    i_imm_can_enq = 1'b0;
    i_br_can_enq = 1'b0;
    dsp_if.dsp_vld = 1'b1;
    tick();
    dsp_if.dsp_vld = 1'b0;
    settle();
    chk("t3_reqs", 64'({o_imm_enq_req, o_br_enq_req}), 64'd0);
    chk("t3_fire", 64'({o_imm_enq_vld, o_br_enq_vld}), 64'b11);
    tick();
    chk("t3_out_slot", 64'(o_out_slot_vld), 64'b0011);
    chk("t3_out_idx", 64'({o_out_imm_idx, o_out_br_idx}), 64'd0);
    chk("t3_stall_cnt", 64'(o_stall_cnt), 64'd3);

    // Output stage back-pressure
    i_imm_can_enq = 1'b1;
    i_br_can_enq = 1'b1;
    i_out_rdy = 1'b0;
    set_grp(4'b1111, 4'b1000, 4'b0001);
    dsp_if.dsp_vld = 1'b1;
    tick();
    dsp_if.dsp_vld = 1'b0;
    settle();
    chk("t4_blocked", 64'({o_imm_enq_vld, o_br_enq_vld}), 64'd0);
    chk("t4_rdy", 64'(dsp_if.dsp_rdy), 64'd0);
    tick();
    chk("t4_out_stable", 64'(o_out_slot_vld), 64'b0011);
    chk("t4_out_vld", 64'(o_out_vld), 64'd1);
    chk("t4_stall_cnt", 64'(o_stall_cnt), 64'd3);
    i_out_rdy = 1'b1;
    settle();
    chk("t4_fire", 64'({o_imm_enq_vld, o_br_enq_vld}), 64'b11);
    tick();
    chk("t4_out_slot", 64'(o_out_slot_vld), 64'b1111);
    chk("t4_out_imm", 64'(o_out_imm_idx), exp_imm(4'b1000));
    chk("t4_out_br", 64'(o_out_br_idx), exp_br(4'b0001));

    // Squash while held and blocked
    i_out_rdy = 1'b0;
    set_grp(4'b1111, 4'b0101, 4'b0010);
    dsp_if.dsp_vld = 1'b1;
    tick();
    dsp_if.dsp_vld = 1'b0;
    i_imm_can_enq = 1'b0;
    i_br_can_enq = 1'b0;
    i_squash = 1'b1;
    settle();
    chk("t5_req_shown", 64'(o_imm_enq_req), 64'b0101);
    chk("t5_no_enq", 64'({o_imm_enq_vld, o_br_enq_vld}), 64'd0);
    chk("t5_rdy", 64'(dsp_if.dsp_rdy), 64'd0);
    tick();
    i_squash = 1'b0;
    i_imm_can_enq = 1'b1;
    i_br_can_enq = 1'b1;
    settle();
    chk("t5_out_vld", 64'(o_out_vld), 64'd0);
    chk("t5_h_empty", 64'(o_imm_enq_req), 64'd0);
    chk("t5_after_enq", 64'(o_imm_enq_vld), 64'd0);
    chk("t5_rdy_back", 64'(dsp_if.dsp_rdy), 64'd1);

    // Back-to-back groups
    i_out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_grp(4'b1111, tbl_ni[k], tbl_nb[k]);
      dsp_if.dsp_vld = 1'b1;
      settle();
      chk("t6_rdy", 64'(dsp_if.dsp_rdy), 64'd1);
      if (k > 0) begin
        chk("t6_imm_req", 64'(o_imm_enq_req), 64'(tbl_ni[k-1]));
        chk("t6_enq", 64'({o_imm_enq_vld, o_br_enq_vld}), 64'b11);
      end
      if (k > 1) begin
        chk("t6_out_vld", 64'(o_out_vld), 64'd1);
        chk("t6_out_imm", 64'(o_out_imm_idx), exp_imm(tbl_ni[k-2]));
      end
      tick();
    end
    dsp_if.dsp_vld = 1'b0;
    settle();
    chk("t6_last_req", 64'(o_br_enq_req), 64'(tbl_nb[3]));
    chk("t6_out_br", 64'(o_out_br_idx), exp_br(tbl_nb[2]));
    tick();
    chk("t6_last_out", 64'(o_out_imm_idx), exp_imm(tbl_ni[3]));

    // Empty group is acknowledged but dropped
    set_grp(4'b0000, 4'b1111, 4'b1111);
    dsp_if.dsp_vld = 1'b1;
    settle();
    chk("t7_rdy", 64'(dsp_if.dsp_rdy), 64'd1);
    tick();
    dsp_if.dsp_vld = 1'b0;
    settle();
    chk("t7_no_req", 64'({o_imm_enq_req, o_br_enq_req}), 64'd0);
    chk("t7_no_enq", 64'(o_imm_enq_vld), 64'd0);
    chk("t7_out_clr", 64'(o_out_vld), 64'd0);

    // Reset in the middle of a stall
    set_grp(4'b1111, 4'b0101, 4'b0010);
    i_br_can_enq = 1'b0;
    dsp_if.dsp_vld = 1'b1;
    tick();
    dsp_if.dsp_vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_br_can_enq = 1'b1;
    settle();
    chk("t8_no_enq", 64'(o_imm_enq_vld), 64'd0);
    chk("t8_h_empty", 64'(o_imm_enq_req), 64'd0);
    chk("t8_stall_clr", 64'(o_stall_cnt), 64'd0);
    chk("t8_rdy", 64'(dsp_if.dsp_rdy), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
